// File: rtl/ex_mem_skid_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_skid_reg_if
//  Brief    : EX->MEM handshake bundle. The EX offer and the MEM-side ready
//             arrive from the environment; the M-side entry and status are
//             returned by the pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
interface ex_mem_skid_reg_if #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int RESULT_SRC_W = 2
);
    // EX side
    logic                    ValidE;
    logic                    ReadyE;
    logic                    FlushE;
    logic                    RegWriteE;
    logic [RESULT_SRC_W-1:0] ResultSrcE;
    logic                    MemWriteE;
    logic [XLEN-1:0]         ALUResultE;
    logic [XLEN-1:0]         WriteDataE;
    logic [REG_ADDR_W-1:0]   RdE;
    logic [XLEN-1:0]         PCPlus4E;

    // MEM side
    logic                    ValidM;
    logic                    ReadyM;
    logic                    RegWriteM;
    logic [RESULT_SRC_W-1:0] ResultSrcM;
    logic                    MemWriteM;
    logic [XLEN-1:0]         ALUResultM;
    logic [XLEN-1:0]         WriteDataM;
    logic [REG_ADDR_W-1:0]   RdM;
    logic [XLEN-1:0]         PCPlus4M;

    // Status
    logic [1:0]              Occupancy;

    // Environment: produces the EX offer and the MEM ready
    modport master (
        output ValidE, FlushE, RegWriteE, ResultSrcE, MemWriteE,
               ALUResultE, WriteDataE, RdE, PCPlus4E, ReadyM,
        input  ReadyE, ValidM, RegWriteM, ResultSrcM, MemWriteM,
               ALUResultM, WriteDataM, RdM, PCPlus4M, Occupancy
    );

    // Pipeline register
    modport slave (
        input  ValidE, FlushE, RegWriteE, ResultSrcE, MemWriteE,
               ALUResultE, WriteDataE, RdE, PCPlus4E, ReadyM,
        output ReadyE, ValidM, RegWriteM, ResultSrcM, MemWriteM,
               ALUResultM, WriteDataM, RdM, PCPlus4M, Occupancy
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_skid_reg
//  Brief    : EX->MEM pipeline register with valid/ready handshake and a
//             one-entry skid buffer. ReadyE is derived from state only, so no
//             combinational path exists from ReadyM back to ReadyE. Flushed
//             offers are dropped and bubbles never carry write enables.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid_reg #(
    parameter int XLEN            = 32,
    parameter int REG_ADDR_W      = 5,
    parameter int RESULT_SRC_W    = 2,
    parameter int ZERO_REG_SQUASH = 1
) (
    input  wire              clk,
    input  wire              rst,
    ex_mem_skid_reg_if.slave bus
);
    // The interface instance must be built with the same widths as this module.

    // Entry layout, MSB first: RegWrite, ResultSrc, MemWrite, ALUResult,
    // WriteData, Rd, PCPlus4.
    localparam int ENTRY_W = 1 + RESULT_SRC_W + 1 + 3 * XLEN + REG_ADDR_W;

    logic [ENTRY_W-1:0] r_out_data;
    logic [ENTRY_W-1:0] r_skd_data;
    logic               r_out_valid;
    logic               r_skd_valid;

    logic               w_ready;
    logic               w_accept;
    logic               w_drain;
    logic               w_squash;
    logic [ENTRY_W-1:0] w_in_entry;
    logic               w_out_regwrite;
    logic               w_out_memwrite;

    // A write to x0 is architecturally a no-op; killing it here saves the
    // writeback stage from special-casing Rd==0.
    assign w_squash   = (ZERO_REG_SQUASH != 0) && (bus.RdE == '0);
    assign w_in_entry = {bus.RegWriteE & ~w_squash, bus.ResultSrcE, bus.MemWriteE,
                         bus.ALUResultE, bus.WriteDataE, bus.RdE, bus.PCPlus4E};

    // Ready only looks at the skid flag (and reset), never at ReadyM.
    assign w_ready  = ~r_skd_valid & ~rst;
    assign w_accept = bus.ValidE & w_ready & ~bus.FlushE;
    assign w_drain  = ~r_out_valid | bus.ReadyM;

    // Storage update: OUT refills from SKD first so ordering is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_skd_data  <= '0;
            r_out_valid <= 1'b0;
            r_skd_valid <= 1'b0;
        end else if (w_drain) begin
            if (r_skd_valid) begin
                r_out_data  <= r_skd_data;
                r_out_valid <= 1'b1;
                if (w_accept) begin
                    r_skd_data <= w_in_entry;
                end
                r_skd_valid <= w_accept;
            end else begin
                if (w_accept) begin
                    r_out_data <= w_in_entry;
                end
                r_out_valid <= w_accept;
            end
        end else if (w_accept) begin
            // OUT is stalled; accept only happens with SKD empty.
            r_skd_data  <= w_in_entry;
            r_skd_valid <= 1'b1;
        end
    end

    assign {w_out_regwrite, bus.ResultSrcM, w_out_memwrite, bus.ALUResultM,
            bus.WriteDataM, bus.RdM, bus.PCPlus4M} = r_out_data;

    // Bubbles keep their data fields but never their write enables.
    assign bus.RegWriteM = w_out_regwrite & r_out_valid;
    assign bus.MemWriteM = w_out_memwrite & r_out_valid;
    assign bus.ValidM    = r_out_valid;
    assign bus.ReadyE    = w_ready;
    assign bus.Occupancy = {1'b0, r_out_valid} + {1'b0, r_skd_valid};

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_skid_reg
//  Brief    : Self-checking bench for ex_mem_skid_reg. A queue of in-flight
//             entries (front = entry shown on the M side) predicts outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid_reg;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t exp_q[$];
    ent_t exp_last;

    ex_mem_skid_reg_if bus ();
    ex_mem_skid_reg_if #(.XLEN(64), .RESULT_SRC_W(3)) bus64 ();

    ex_mem_skid_reg u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ex_mem_skid_reg #(.XLEN(64), .RESULT_SRC_W(3)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the reference queue from the inputs as
    // they stood at the edge. Returns 1 time unit after the edge.
    task automatic step();
        ent_t e;
        bit   acc;
        bit   pop;
        acc = bus.ValidE && !bus.FlushE && !rst && (exp_q.size() < 2);
        pop = (exp_q.size() > 0) && bus.ReadyM;
        e.rw  = bus.RegWriteE && (bus.RdE != 5'd0);
        e.rs  = bus.ResultSrcE;
        e.mw  = bus.MemWriteE;
        e.alu = bus.ALUResultE;
        e.wd  = bus.WriteDataE;
        e.rd  = bus.RdE;
        e.pc  = bus.PCPlus4E;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_last = '0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
            if (exp_q.size() > 0) exp_last = exp_q[0];
        end
        #1;
    endtask

    task automatic offer(input logic [31:0] alu);
        bus.ValidE     = 1'b1;
        bus.FlushE     = 1'b0;
        bus.RegWriteE  = 1'b1;
        bus.ResultSrcE = 2'd1;
        bus.MemWriteE  = 1'b0;
        bus.ALUResultE = alu;
        bus.WriteDataE = ~alu;
        bus.RdE        = 5'd3;
        bus.PCPlus4E   = alu + 32'd4;
    endtask

    task automatic idle();
        bus.ValidE    = 1'b0;
        bus.FlushE    = 1'b0;
        bus.MemWriteE = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (bus.ValidM !== 1'b0) begin n_fail++; $display("FAIL reset_validm: got %b expected 0", bus.ValidM); end
        n_checks++; if (bus.Occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", bus.Occupancy); end
        n_checks++; if (bus.ReadyE !== 1'b0) begin n_fail++; $display("FAIL reset_readye_in_rst: got %b expected 0", bus.ReadyE); end
        n_checks++; if (bus.ALUResultM !== 32'd0) begin n_fail++; $display("FAIL reset_alum: got %h expected 0", bus.ALUResultM); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.ReadyE !== 1'b1) begin n_fail++; $display("FAIL reset_readye_release: got %b expected 1", bus.ReadyE); end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        bus.ReadyM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h10 + 32'(4 * i);
            offer(a);
            step();
            n_checks++; if (bus.ALUResultM !== a) begin n_fail++; $display("FAIL stream_alu[%0d]: got %h expected %h", i, bus.ALUResultM, a); end
            n_checks++; if (bus.ValidM !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.ValidM); end
            n_checks++; if (bus.ReadyE !== 1'b1) begin n_fail++; $display("FAIL stream_readye[%0d]: got %b expected 1", i, bus.ReadyE); end
        end
        idle();
        step();
        n_checks++; if (bus.ValidM !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b expected 0", bus.ValidM); end
        n_checks++; if (bus.ALUResultM !== 32'h1C) begin n_fail++; $display("FAIL stream_bubble_hold: got %h expected 0000001c", bus.ALUResultM); end
    endtask

    task automatic test_stall();
        bus.ReadyM = 1'b0;
        offer(32'h100);
        step();
        offer(32'h200);
        step();
        n_checks++; if (bus.Occupancy !== 2'd2) begin n_fail++; $display("FAIL stall_occ: got %0d expected 2", bus.Occupancy); end
        n_checks++; if (bus.ReadyE !== 1'b0) begin n_fail++; $display("FAIL stall_readye: got %b expected 0", bus.ReadyE); end
        idle();
        step();
        n_checks++; if (bus.ALUResultM !== 32'h100) begin n_fail++; $display("FAIL stall_hold_a: got %h expected 00000100", bus.ALUResultM); end
        bus.ReadyM = 1'b1;
        #1;
        n_checks++; if (bus.ReadyE !== 1'b0) begin n_fail++; $display("FAIL stall_readye_no_comb: got %b expected 0", bus.ReadyE); end
        step();
        n_checks++; if (bus.ALUResultM !== 32'h200) begin n_fail++; $display("FAIL stall_show_b: got %h expected 00000200", bus.ALUResultM); end
        n_checks++; if (bus.ReadyE !== 1'b1) begin n_fail++; $display("FAIL stall_readye_back: got %b expected 1", bus.ReadyE); end
        n_checks++; if (bus.Occupancy !== 2'd1) begin n_fail++; $display("FAIL stall_occ_after: got %0d expected 1", bus.Occupancy); end
        step();
        n_checks++; if (bus.ValidM !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got %b expected 0", bus.ValidM); end
    endtask

    task automatic test_flush();
        bus.ReadyM = 1'b1;
        offer(32'h0BAD);
        bus.FlushE    = 1'b1;
        bus.MemWriteE = 1'b1;
        step();
        n_checks++; if (bus.ValidM !== 1'b0) begin n_fail++; $display("FAIL flush_validm: got %b expected 0", bus.ValidM); end
        n_checks++; if (bus.MemWriteM !== 1'b0) begin n_fail++; $display("FAIL flush_memwritem: got %b expected 0", bus.MemWriteM); end
        n_checks++; if (bus.Occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", bus.Occupancy); end
        bus.ReadyM = 1'b0;
        offer(32'hC0);
        step();
        offer(32'hD0);
        step();
        offer(32'hBAD0);
        bus.FlushE = 1'b1;
        step();
        n_checks++; if (bus.Occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_full_occ: got %0d expected 2", bus.Occupancy); end
        idle();
        bus.ReadyM = 1'b1;
        step();
        n_checks++; if (bus.ALUResultM !== 32'hD0) begin n_fail++; $display("FAIL flush_skid_intact: got %h expected 000000d0", bus.ALUResultM); end
        step();
    endtask

    task automatic test_squash();
        bus.ReadyM = 1'b1;
        offer(32'hDEAD);
        bus.RdE = 5'd0;
        step();
        n_checks++; if (bus.RegWriteM !== 1'b0) begin n_fail++; $display("FAIL squash_rw_x0: got %b expected 0", bus.RegWriteM); end
        n_checks++; if (bus.ALUResultM !== 32'hDEAD) begin n_fail++; $display("FAIL squash_alu: got %h expected 0000dead", bus.ALUResultM); end
        n_checks++; if (bus.ValidM !== 1'b1) begin n_fail++; $display("FAIL squash_valid: got %b expected 1", bus.ValidM); end
        bus.RdE = 5'd5;
        step();
        n_checks++; if (bus.RegWriteM !== 1'b1) begin n_fail++; $display("FAIL squash_rw_x5: got %b expected 1", bus.RegWriteM); end
        idle();
        step();
    endtask

    task automatic test_reset_midstall();
        bus.ReadyM = 1'b0;
        offer(32'hE0);
        step();
        offer(32'hF0);
        step();
        idle();
        rst = 1'b1;
        step();
        n_checks++; if (bus.ValidM !== 1'b0) begin n_fail++; $display("FAIL rststall_validm: got %b expected 0", bus.ValidM); end
        n_checks++; if (bus.ALUResultM !== 32'd0) begin n_fail++; $display("FAIL rststall_alum: got %h expected 0", bus.ALUResultM); end
        n_checks++; if (bus.PCPlus4M !== 32'd0) begin n_fail++; $display("FAIL rststall_pcm: got %h expected 0", bus.PCPlus4M); end
        n_checks++; if (bus.ReadyE !== 1'b0) begin n_fail++; $display("FAIL rststall_readye: got %b expected 0", bus.ReadyE); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.ReadyE !== 1'b1) begin n_fail++; $display("FAIL rststall_readye_after: got %b expected 1", bus.ReadyE); end
        n_checks++; if (bus.Occupancy !== 2'd0) begin n_fail++; $display("FAIL rststall_occ: got %0d expected 0", bus.Occupancy); end
    endtask

    task automatic test_params();
        idle();
        bus64.ValidE     = 1'b1;
        bus64.ReadyM     = 1'b1;
        bus64.RegWriteE  = 1'b1;
        bus64.RdE        = 5'd7;
        bus64.ResultSrcE = 3'b101;
        bus64.PCPlus4E   = 64'hFFFF_FFFF_0000_0004;
        bus64.ALUResultE = 64'h1234_5678_9ABC_DEF0;
        step();
        n_checks++; if (bus64.PCPlus4M !== 64'hFFFF_FFFF_0000_0004) begin n_fail++; $display("FAIL param_pc64: got %h expected ffffffff00000004", bus64.PCPlus4M); end
        n_checks++; if (bus64.ResultSrcM !== 3'b101) begin n_fail++; $display("FAIL param_rs3: got %b expected 101", bus64.ResultSrcM); end
        n_checks++; if (bus64.ALUResultM !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL param_alu64: got %h expected 123456789abcdef0", bus64.ALUResultM); end
        n_checks++; if (bus64.RegWriteM !== 1'b1) begin n_fail++; $display("FAIL param_rw: got %b expected 1", bus64.RegWriteM); end
        bus64.ValidE = 1'b0;
        step();
        n_checks++; if (bus64.ValidM !== 1'b0) begin n_fail++; $display("FAIL param_bubble: got %b expected 0", bus64.ValidM); end
        n_checks++; if (bus64.RegWriteM !== 1'b0) begin n_fail++; $display("FAIL param_bubble_rw: got %b expected 0", bus64.RegWriteM); end
    endtask

    task automatic test_random();
        bit   ev;
        ent_t el;
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.ValidE     = ($urandom_range(0, 3) != 0);
            bus.FlushE     = ($urandom_range(0, 5) == 0);
            bus.ReadyM     = (i % 64 < 20) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
            bus.RegWriteE  = 1'($urandom);
            bus.ResultSrcE = 2'($urandom);
            bus.MemWriteE  = 1'($urandom);
            bus.ALUResultE = $urandom;
            bus.WriteDataE = $urandom;
            bus.RdE        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            bus.PCPlus4E   = $urandom;
            step();
            ev = (exp_q.size() > 0);
            el = exp_last;
            n_checks++; if (bus.ValidM !== ev) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.ValidM, ev); end
            n_checks++; if (bus.Occupancy !== 2'(exp_q.size())) begin n_fail++; $display("FAIL rnd_occ[%0d]: got %0d expected %0d", i, bus.Occupancy, exp_q.size()); end
            n_checks++; if (bus.ReadyE !== (!rst && exp_q.size() < 2)) begin n_fail++; $display("FAIL rnd_readye[%0d]: got %b expected %b", i, bus.ReadyE, (!rst && exp_q.size() < 2)); end
            n_checks++; if (bus.RegWriteM !== (el.rw && ev)) begin n_fail++; $display("FAIL rnd_rw[%0d]: got %b expected %b", i, bus.RegWriteM, (el.rw && ev)); end
            n_checks++; if (bus.MemWriteM !== (el.mw && ev)) begin n_fail++; $display("FAIL rnd_mw[%0d]: got %b expected %b", i, bus.MemWriteM, (el.mw && ev)); end
            n_checks++; if (bus.ResultSrcM !== el.rs) begin n_fail++; $display("FAIL rnd_rs[%0d]: got %h expected %h", i, bus.ResultSrcM, el.rs); end
            n_checks++; if (bus.ALUResultM !== el.alu) begin n_fail++; $display("FAIL rnd_alu[%0d]: got %h expected %h", i, bus.ALUResultM, el.alu); end
            n_checks++; if (bus.WriteDataM !== el.wd) begin n_fail++; $display("FAIL rnd_wd[%0d]: got %h expected %h", i, bus.WriteDataM, el.wd); end
            n_checks++; if (bus.RdM !== el.rd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %h expected %h", i, bus.RdM, el.rd); end
            n_checks++; if (bus.PCPlus4M !== el.pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, bus.PCPlus4M, el.pc); end
        end
        rst = 1'b0;
        idle();
        bus.ReadyM = 1'b1;
        step();
        step();
        step();
    endtask

    initial begin
        exp_last         = '0;
        rst              = 1'b1;
        bus.ValidE       = 1'b0;
        bus.FlushE       = 1'b0;
        bus.RegWriteE    = 1'b0;
        bus.ResultSrcE   = '0;
        bus.MemWriteE    = 1'b0;
        bus.ALUResultE   = '0;
        bus.WriteDataE   = '0;
        bus.RdE          = '0;
        bus.PCPlus4E     = '0;
        bus.ReadyM       = 1'b0;
        bus64.ValidE     = 1'b0;
        bus64.FlushE     = 1'b0;
        bus64.RegWriteE  = 1'b0;
        bus64.ResultSrcE = '0;
        bus64.MemWriteE  = 1'b0;
        bus64.ALUResultE = '0;
        bus64.WriteDataE = '0;
        bus64.RdE        = '0;
        bus64.PCPlus4E   = '0;
        bus64.ReadyM     = 1'b0;

        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_squash();
        test_reset_midstall();
        test_params();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
